// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath sharing one memory for fetch and data.
// Mealy on mem_ready in FETCH/MEM; wait counter bounds every memory access.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [1:0] ResultSrc,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [3:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;
  logic       retire_q, retire_d;
  logic       timeout;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    Branch    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    ResultSrc = 2'b00;
    // Fifteen cycles already spent waiting; a late mem_ready still wins.
    timeout   = (wait_q == 4'd15) && !mem_ready;

    case (state_q)
      S_FETCH: begin
        if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          MemReq  = 1'b1;
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b10;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) state_d = S_DECODE;
          else           wait_d  = wait_q + 4'd1;
        end
      end
      S_DECODE: begin
        op_d    = Opcode;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (is_legal(Opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R:      begin ALUOp = 2'b10; state_d = S_WB; end
          OP_I:      begin ALUSrcB = 2'b01; ALUOp = 2'b11; state_d = S_WB; end
          OP_LOAD,
          OP_STORE:  begin ALUSrcB = 2'b01; state_d = S_MEM; end
          OP_BRANCH: begin ALUOp = 2'b01; Branch = 1'b1; PCSrc = 2'b01; state_d = S_FETCH; end
          OP_JAL:    begin PCWrite = 1'b1; PCSrc = 2'b01; state_d = S_WB; end
          OP_JALR:   begin ALUSrcB = 2'b01; PCWrite = 1'b1; state_d = S_WB; end
          OP_LUI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; state_d = S_WB; end
          OP_AUIPC:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; state_d = S_WB; end
          default:   begin state_d = S_TRAP; cause_d = CAUSE_ILLEGAL; end
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          MemReq   = 1'b1;
          MemWrite = (op_q == OP_STORE);
          if (!mem_ready)            wait_d  = wait_q + 4'd1;
          else if (op_q == OP_STORE) state_d = S_FETCH;
          else                       state_d = S_WB;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (op_q == OP_LOAD)                         ResultSrc = 2'b01;
        else if (op_q == OP_JAL || op_q == OP_JALR)  ResultSrc = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) wait_d = 4'd0;

    retire_d = (state_d == S_FETCH) &&
               (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= S_FETCH;
      op_q     <= 7'd0;
      wait_q   <= 4'd0;
      cause_q  <= 2'b00;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      cause_q  <= cause_d;
      retire_q <= retire_d;
    end
  end

  assign instr_retired = retire_q;
  assign trap          = (state_q == S_TRAP);
  assign trap_cause    = cause_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench: an instruction-level model emits one expected output record per
// cycle; a negedge monitor pops and compares against the controller outputs.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, mreq, mwr, rw, br;
    logic [1:0] asa, asb, aop, pcs, rs;
    logic       ret, trap;
    logic [1:0] cause;
  } exp_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, MemReq, MemWrite, RegWrite, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, PCSrc, ResultSrc;
  logic       instr_retired, trap;
  logic [1:0] trap_cause;
  logic [2:0] state_dbg;

  multicycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .Opcode        (Opcode),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .IRWrite       (IRWrite),
    .MemReq        (MemReq),
    .MemWrite      (MemWrite),
    .RegWrite      (RegWrite),
    .Branch        (Branch),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .PCSrc         (PCSrc),
    .ResultSrc     (ResultSrc),
    .instr_retired (instr_retired),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  exp_t exp_q [$];
  exp_t act;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic pending_ret;  // a completed instruction owes a retire pulse to the next FETCH cycle

  always_comb begin
    act       = '0;
    act.st    = state_dbg;
    act.pcw   = PCWrite;
    act.irw   = IRWrite;
    act.mreq  = MemReq;
    act.mwr   = MemWrite;
    act.rw    = RegWrite;
    act.br    = Branch;
    act.asa   = ALUSrcA;
    act.asb   = ALUSrcB;
    act.aop   = ALUOp;
    act.pcs   = PCSrc;
    act.rs    = ResultSrc;
    act.ret   = instr_retired;
    act.trap  = trap;
    act.cause = trap_cause;
  end

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h (state %0d) want %h (state %0d)", name, got, got.st, want, want.st);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cycle %0d", cyc), act, e);
    end
  end

  // ---------------- reference model: expected outputs per phase ----------------
  function automatic logic is_legal(input logic [6:0] op);
    is_legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) is_legal = 1'b1;
  endfunction

  function automatic exp_t e_fetch(input logic mr, input logic ret);
    exp_t e = '0;
    e.st = 3'd0; e.mreq = 1'b1; e.asa = 2'b11; e.asb = 2'b10;
    e.irw = mr; e.pcw = mr; e.ret = ret;
    return e;
  endfunction

  function automatic exp_t e_stall(input logic [2:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic exp_t e_decode();
    exp_t e = '0;
    e.st = 3'd1; e.asa = 2'b01; e.asb = 2'b01;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [6:0] op);
    exp_t e = '0;
    e.st = 3'd2;
    case (op)
      OP_R:      e.aop = 2'b10;
      OP_I:      begin e.asb = 2'b01; e.aop = 2'b11; end
      OP_LOAD:   e.asb = 2'b01;
      OP_STORE:  e.asb = 2'b01;
      OP_BRANCH: begin e.aop = 2'b01; e.br = 1'b1; e.pcs = 2'b01; end
      OP_JAL:    begin e.pcw = 1'b1; e.pcs = 2'b01; end
      OP_JALR:   begin e.asb = 2'b01; e.pcw = 1'b1; end
      OP_LUI:    begin e.asa = 2'b10; e.asb = 2'b01; end
      OP_AUIPC:  begin e.asa = 2'b01; e.asb = 2'b01; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t e_mem(input logic [6:0] op);
    exp_t e = '0;
    e.st = 3'd3; e.mreq = 1'b1; e.mwr = (op == OP_STORE);
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [6:0] op);
    exp_t e = '0;
    e.st = 3'd4; e.rw = 1'b1;
    if (op == OP_LOAD)                      e.rs = 2'b01;
    else if (op == OP_JAL || op == OP_JALR) e.rs = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_trap(input logic [1:0] cause);
    exp_t e = '0;
    e.st = 3'd5; e.trap = 1'b1; e.cause = cause;
    return e;
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input bit push, input exp_t e, input logic [6:0] op,
                      input logic mr, input logic rs);
    Opcode    = op;
    mem_ready = mr;
    reset     = rs;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, rnd_op(), rnd_bit(), 1'b1);
    pending_ret = 1'b0;
  endtask

  task automatic trap_cycles(input logic [1:0] cause);
    for (int i = 0; i < 20; i++) step(1'b1, e_trap(cause), rnd_op(), rnd_bit(), 1'b0);
    do_reset(2);
  endtask

  // fw/mw: waiting cycles before memory answers in FETCH/MEM (>=16 times out);
  // abort_mem: MEM cycle index at which reset is asserted, -1 for none.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int abort_mem);
    logic mr;
    for (int c = 0; c < 16; c++) begin
      mr = (c >= fw);
      if (c == 15 && !mr) begin
        step(1'b1, e_stall(3'd0), rnd_op(), 1'b0, 1'b0);
        trap_cycles(2'b10);
        return;
      end
      step(1'b1, e_fetch(mr, (c == 0) ? pending_ret : 1'b0), rnd_op(), mr, 1'b0);
      if (mr) break;
    end
    pending_ret = 1'b0;

    step(1'b1, e_decode(), op, rnd_bit(), 1'b0);
    if (!is_legal(op)) begin
      trap_cycles(2'b01);
      return;
    end

    step(1'b1, e_exec(op), rnd_op(), rnd_bit(), 1'b0);
    if (op == OP_BRANCH) begin
      pending_ret = 1'b1;
      return;
    end

    if (op == OP_LOAD || op == OP_STORE) begin
      for (int c = 0; c < 16; c++) begin
        mr = (c >= mw);
        if (c == abort_mem) begin
          do_reset(1);
          return;
        end
        if (c == 15 && !mr) begin
          step(1'b1, e_stall(3'd3), rnd_op(), 1'b0, 1'b0);
          trap_cycles(2'b10);
          return;
        end
        step(1'b1, e_mem(op), rnd_op(), mr, 1'b0);
        if (mr) break;
      end
      if (op == OP_STORE) begin
        pending_ret = 1'b1;
        return;
      end
    end

    step(1'b1, e_wb(op), rnd_op(), rnd_bit(), 1'b0);
    pending_ret = 1'b1;
  endtask

  initial begin
    logic [6:0] op;
    int fw, mw, ab;
    pending_ret = 1'b0;
    do_reset(2);

    run_instr(OP_R,      0, 0, -1);
    run_instr(OP_LOAD,   0, 3, -1);
    run_instr(OP_STORE,  0, 2, -1);
    run_instr(OP_BRANCH, 0, 0, -1);
    run_instr(OP_JAL,    1, 0, -1);
    run_instr(OP_JALR,   0, 0, -1);
    run_instr(OP_LUI,    2, 0, -1);
    run_instr(OP_AUIPC,  0, 0, -1);
    run_instr(OP_I,      0, 0, -1);
    run_instr(7'h7F,     0, 0, -1);
    run_instr(OP_R,     16, 0, -1);
    run_instr(OP_R,     15, 0, -1);
    run_instr(OP_LOAD,   0, 16, -1);
    run_instr(OP_STORE,  0, 15, -1);
    run_instr(OP_STORE,  0, 5,  2);
    run_instr(OP_BRANCH, 0, 0, -1);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? rnd_op() : legal_ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1;
      run_instr(op, fw, mw, ab);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Opcode, input, 7 bits: instruction[6:0] from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1 bit: unified memory has completed the current access.
REQ-005 SHALL have ports PCWrite, IRWrite, MemReq, MemWrite, RegWrite, Branch, outputs, 1 bit each: datapath strobes.
REQ-006 SHALL have ports ALUSrcA, ALUSrcB, ALUOp, PCSrc, ResultSrc, outputs, 2 bits each: datapath selects.
REQ-007 SHALL have port instr_retired, output, 1 bit: one-cycle pulse per completed instruction.
REQ-008 SHALL have port trap, output, 1 bit, and trap_cause, output, 2 bits: 01 illegal opcode, 10 memory timeout.
REQ-009 SHALL have port state_dbg, output, 3 bits: current state encoding.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH.
REQ-011 Encodings: ALUSrcA 00 rs1, 01 OldPC, 10 zero, 11 PC; ALUSrcB 00 rs2, 01 imm, 10 const 4; ALUOp 00 add, 01 branch compare, 10 R-type, 11 I-type; PCSrc 00 ALU result, 01 ALUOut; ResultSrc 00 ALUOut, 01 memory data, 10 OldPC+4.
REQ-012 Strobes not listed for a state SHALL be 0 and selects 00.
REQ-013 FETCH: MemReq=1, ALUSrcA=11, ALUSrcB=10; IRWrite=PCWrite=mem_ready; on mem_ready -> DECODE, else stay.
REQ-014 DECODE: Opcode SHALL be latched into an internal register; ALUSrcA=01, ALUSrcB=01 (target into ALUOut); legal opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111) -> EXEC; other -> TRAP, cause 01.
REQ-015 EXEC outputs by latched opcode: R: ALUOp=10 -> WB; I-comp: ALUSrcB=01, ALUOp=11 -> WB; load/store: ALUSrcB=01 -> MEM; branch: ALUOp=01, Branch=1, PCSrc=01 -> FETCH; JAL: PCWrite=1, PCSrc=01 -> WB; JALR: ALUSrcB=01, PCWrite=1, PCSrc=00 -> WB; LUI: ALUSrcA=10, ALUSrcB=01 -> WB; AUIPC: ALUSrcA=01, ALUSrcB=01 -> WB.
REQ-016 MEM: MemReq=1, MemWrite=1 for store; stay until mem_ready; then store -> FETCH, load -> WB.
REQ-017 WB: RegWrite=1; ResultSrc=01 load, 10 JAL/JALR, 00 otherwise; -> FETCH.
REQ-018 instr_retired SHALL be 1 in exactly the cycle of every transition into FETCH other than from reset or TRAP.
REQ-019 Cycle counts with mem_ready=1 on first request cycle: branch/store 3/4, R/I/LUI/AUIPC/JAL/JALR 4, load 5.
REQ-020 A 4-bit wait counter SHALL clear on entering FETCH or MEM, increment each cycle MemReq=1 and mem_ready=0, and on reaching 15 -> TRAP, cause 10, with no strobe that cycle.
REQ-021 mem_ready SHALL be ignored in states other than FETCH and MEM.
REQ-022 mem_ready in the same cycle the counter reaches 15 SHALL win: access completes, no trap.
REQ-023 TRAP: trap=1, trap_cause held, all strobes 0, held until reset.

Reset
REQ-024 While reset=1 at a clock edge: state <- FETCH, wait counter, latched opcode, trap_cause <- 0; registered outputs 0.
REQ-025 Reset SHALL override every transition, including mid-MEM and TRAP; no strobe SHALL assert in the cycle following reset deassertion except FETCH's MemReq.
REQ-026 After reset deasserts, first cycle SHALL be FETCH with MemReq=1, instr_retired=0.

Verification
REQ-027 R-type 0110011, mem_ready=1: states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=10 in EXEC; one retire pulse.
REQ-028 Load 0000011, mem_ready low 3 cycles in MEM: MEM held 4 cycles with MemReq=1, MemWrite=0; then WB with ResultSrc=01.
REQ-029 Store 0100011: MEM MemWrite=1 until ready; no RegWrite; returns to FETCH in 4 cycles.
REQ-030 Opcode 1111111 in DECODE: TRAP, trap=1, trap_cause=01, all strobes 0 for 20 cycles; reset -> FETCH.
REQ-031 mem_ready held 0 in FETCH: TRAP with cause 10 after 15 waiting cycles; mem_ready at count 15 -> DECODE instead.
REQ-032 reset asserted during MEM of a store: next cycle FETCH, MemWrite=0, no retire pulse.
